shift_arbiter: RTL and testbench

- Shares one SLL barrel-shifter instance (Shifter block: dataA, dataB, Signal, dataOut) between two requesters.
- Each requester uses a valid/ready request channel. Results return on one shared response channel tagged with the requester ID.
- The block arbitrates round-robin, registers the operands, drives the shifter for exactly one cycle, captures the result and holds it until the response is accepted.
- Sits between the ALU issue logic and the Shifter instance.

---
 rtl/shift_arbiter.sv | 175 +++++++++++++++++
 tb/tb_shift_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/shift_arbiter.sv
// shift_arbiter: shares one SLL barrel-shifter instance between two
// valid/ready requesters. It grants one requester, registers its operands,
// drives the shifter for exactly one cycle, captures the result and holds it
// on a tagged response channel until the consumer accepts it.
//
// Build option: define SHIFT_ARB_FIXED_PRIO_EN to make requester 0 always
// win a tie (last_grant is still tracked but unused). Without the macro,
// ties are resolved round-robin.

module shift_arbiter #(
  parameter int          DATA_W   = 32,
  parameter logic [5:0]  SLL_CODE = 6'b000010,
  parameter int          CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic [DATA_W-1:0] sh_dataA,
  output logic [DATA_W-1:0] sh_dataB,
  output logic [5:0]        sh_Signal,
  input  logic [DATA_W-1:0] sh_dataOut,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_id,
  output logic              busy,
  output logic [CNT_W-1:0]  ops_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t              state;
  logic                last_grant;

  logic                gnt_any;
  logic                gnt_id;
  logic [DATA_W-1:0]   sel_a;
  logic [DATA_W-1:0]   sel_b;

  logic [DATA_W-1:0]   opa_p0;
  logic [DATA_W-1:0]   opb_p0;
  logic                id_p0;

  logic [DATA_W-1:0]   sh_a_p0;
  logic [DATA_W-1:0]   sh_b_p0;
  logic [5:0]          sh_sig_p0;

  logic [DATA_W-1:0]   rsp_data_p1;
  logic                vld_p1;
  logic                busy_q;
  logic [CNT_W-1:0]    ops_done_q;

  // Tie-break between two simultaneous requests.
  function automatic logic pick_on_tie(input logic last);
`ifdef SHIFT_ARB_FIXED_PRIO_EN
    pick_on_tie = 1'b0;
`else
    pick_on_tie = ~last;
`endif
  endfunction

  // Wrapping increment of the completed-operation counter.
  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] cnt);
    cnt_inc = cnt + CNT_W'(1);
  endfunction

  // Grant decision: only in IDLE and never while reset is being applied,
  // so a handshake can never be taken and then discarded by reset.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = 1'b0;
    if (state == IDLE && reset) begin
      if (req0_valid && req1_valid) begin
        gnt_any = 1'b1;
        gnt_id  = pick_on_tie(last_grant);
      end else if (req0_valid) begin
        gnt_any = 1'b1;
        gnt_id  = 1'b0;
      end else if (req1_valid) begin
        gnt_any = 1'b1;
        gnt_id  = 1'b1;
      end
    end
  end

  assign req0_ready = gnt_any & ~gnt_id;
  assign req1_ready = gnt_any &  gnt_id;
  assign sel_a      = gnt_id ? req1_a : req0_a;
  assign sel_b      = gnt_id ? req1_b : req0_b;

  // Arbitration FSM with operand capture, shifter drive and response hold.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      opa_p0      <= '0;
      opb_p0      <= '0;
      id_p0       <= 1'b0;
      sh_a_p0     <= '0;
      sh_b_p0     <= '0;
      sh_sig_p0   <= 6'b0;
      rsp_data_p1 <= '0;
      vld_p1      <= 1'b0;
      busy_q      <= 1'b0;
      ops_done_q  <= '0;
    end else begin
      case (state)
        // Stage p0: grant edge, operands and requester tag captured.
        IDLE: begin
          if (gnt_any) begin
            opa_p0     <= sel_a;
            opb_p0     <= sel_b;
            id_p0      <= gnt_id;
            last_grant <= gnt_id;
            sh_a_p0    <= sel_a;
            sh_b_p0    <= sel_b;
            sh_sig_p0  <= SLL_CODE;
            busy_q     <= 1'b1;
            state      <= ISSUE;
          end
        end
        // Stage p1: shifter result captured, shifter inputs parked at zero.
        ISSUE: begin
          rsp_data_p1 <= sh_dataOut;
          vld_p1      <= 1'b1;
          sh_a_p0     <= '0;
          sh_b_p0     <= '0;
          sh_sig_p0   <= 6'b0;
          state       <= RESP;
        end
        // Response held until the consumer takes it.
        RESP: begin
          if (rsp_ready) begin
            vld_p1     <= 1'b0;
            busy_q     <= 1'b0;
            ops_done_q <= cnt_inc(ops_done_q);
            state      <= IDLE;
          end
        end
        default: begin
          vld_p1    <= 1'b0;
          busy_q    <= 1'b0;
          sh_a_p0   <= '0;
          sh_b_p0   <= '0;
          sh_sig_p0 <= 6'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  // The registered shifter drive equals the operand registers during ISSUE
  // and zero elsewhere, so the shared shifter stays quiet between operations.
  assign sh_dataA  = sh_a_p0;
  assign sh_dataB  = sh_b_p0;
  assign sh_Signal = sh_sig_p0;

  assign rsp_valid = vld_p1;
  assign rsp_data  = rsp_data_p1;
  assign rsp_id    = id_p0;
  assign busy      = busy_q;
  assign ops_done  = ops_done_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Testbench for shift_arbiter: directed and randomized transactions checked
// against a transaction-level reference model (grant rule, a << (b mod 32),
// wrapping completion count). The shifter is modelled behaviourally here.

module tb_shift_arbiter;
  localparam int         DATA_W = 32;
  localparam int         CNT_W  = 8;
  localparam logic [5:0] SLL    = 6'b000010;

  logic              clk = 1'b0;
  logic              reset;
  logic              req0_valid, req0_ready;
  logic [DATA_W-1:0] req0_a, req0_b;
  logic              req1_valid, req1_ready;
  logic [DATA_W-1:0] req1_a, req1_b;
  logic [DATA_W-1:0] sh_dataA, sh_dataB, sh_dataOut;
  logic [5:0]        sh_Signal;
  logic              rsp_valid, rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_id, busy;
  logic [CNT_W-1:0]  ops_done;

  int checks   = 0;
  int failures = 0;
  int m_last;
  int m_ops;

  shift_arbiter #(.DATA_W(DATA_W), .SLL_CODE(SLL), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .sh_dataA(sh_dataA), .sh_dataB(sh_dataB), .sh_Signal(sh_Signal), .sh_dataOut(sh_dataOut),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .busy(busy), .ops_done(ops_done)
  );

  always #5 clk = ~clk;

  // Behavioural SLL shifter: only the low five amount bits matter.
  assign sh_dataOut = sh_dataA << (sh_dataB % 32);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full operation: present requests, check grant, issue, response.
  task automatic transact(input bit v0, input logic [31:0] a0, input logic [31:0] b0,
                          input bit v1, input logic [31:0] a1, input logic [31:0] b1,
                          input int hold);
    int win;
    logic [31:0] ea, eb, er;
    req0_valid = v0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_a = a1; req1_b = b1;
    rsp_ready  = 1'b0;
    #1;
    if (v0 && v1) begin
`ifdef SHIFT_ARB_FIXED_PRIO_EN
      win = 0;
`else
      win = (m_last == 0) ? 1 : 0;
`endif
    end else begin
      win = v0 ? 0 : 1;
    end
    ea = (win == 1) ? a1 : a0;
    eb = (win == 1) ? b1 : b0;
    er = ea << (eb % 32);
    check("idle_busy", busy, 0);
    check("grant_ready0", req0_ready, win == 0);
    check("grant_ready1", req1_ready, win == 1);
    step();
    m_last = win;
    check("issue_busy", busy, 1);
    check("issue_rsp_valid", rsp_valid, 0);
    check("issue_sh_dataA", sh_dataA, ea);
    check("issue_sh_dataB", sh_dataB, eb);
    check("issue_sh_Signal", sh_Signal, SLL);
    check("issue_ready0", req0_ready, 0);
    check("issue_ready1", req1_ready, 0);
    step();
    check("resp_valid", rsp_valid, 1);
    check("resp_data", rsp_data, er);
    check("resp_id", rsp_id, win);
    check("resp_sh_Signal", sh_Signal, 0);
    check("resp_sh_dataA", sh_dataA, 0);
    check("resp_sh_dataB", sh_dataB, 0);
    for (int i = 0; i < hold; i++) begin
      step();
      check("hold_valid", rsp_valid, 1);
      check("hold_data", rsp_data, er);
      check("hold_id", rsp_id, win);
      check("hold_ready0", req0_ready, 0);
      check("hold_ready1", req1_ready, 0);
      check("hold_sh_Signal", sh_Signal, 0);
      check("hold_busy", busy, 1);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    m_ops = (m_ops + 1) % (1 << CNT_W);
    check("hs_rsp_valid", rsp_valid, 0);
    check("hs_busy", busy, 0);
    check("hs_ops_done", ops_done, m_ops);
  endtask

  initial begin
    logic [1:0] v;
    reset = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0;
    rsp_ready = 1'b0;
    m_last = 1;
    m_ops  = 0;

    // Reset state.
    repeat (3) step();
    check("rst_ready0", req0_ready, 0);
    check("rst_ready1", req1_ready, 0);
    check("rst_sh_dataA", sh_dataA, 0);
    check("rst_sh_dataB", sh_dataB, 0);
    check("rst_sh_Signal", sh_Signal, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_busy", busy, 0);
    check("rst_ops_done", ops_done, 0);
    reset = 1'b1;
    step();

    // Single request from requester 0: 1 << 4.
    transact(1'b1, 32'h0000_0001, 32'd4, 1'b0, 32'h0, 32'h0, 0);
    check("t1_data_const", rsp_data, 32'h0000_0010);
    check("t1_ops_const", ops_done, 1);

    // Both requesters held: grants alternate (or stay on 0 with fixed priority).
    for (int k = 0; k < 4; k++)
      transact(1'b1, 32'h8000_0001, 32'd1, 1'b1, 32'h0000_0001, 32'd31, 0);

    // Amount 0x25 uses only its low five bits (5).
    transact(1'b0, 32'h0, 32'h0, 1'b1, 32'h0000_0001, 32'h25, 0);
    check("amt37_const", rsp_data, 32'h0000_0020);

    // Consumer stalls for ten cycles.
    transact(1'b1, 32'h1234_5678, 32'd8, 1'b0, 32'h0, 32'h0, 10);

    // Valid withdrawn before the edge: nothing is granted.
    req0_valid = 1'b1; req0_a = 32'hDEAD_BEEF; req0_b = 32'd3;
    #2;
    req0_valid = 1'b0;
    step();
    check("drop_busy", busy, 0);
    check("drop_sh_Signal", sh_Signal, 0);
    step();
    check("drop_rsp_valid", rsp_valid, 0);

    // Reset during ISSUE discards the operation.
    req1_valid = 1'b1; req1_a = 32'h0000_00FF; req1_b = 32'd2;
    step();
    check("pre_rst_busy", busy, 1);
    reset = 1'b0;
    req1_valid = 1'b0;
    step();
    check("midrst_busy", busy, 0);
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_ops_done", ops_done, 0);
    check("midrst_sh_dataA", sh_dataA, 0);
    check("midrst_sh_dataB", sh_dataB, 0);
    check("midrst_sh_Signal", sh_Signal, 0);
    check("midrst_ready1", req1_ready, 0);
    reset = 1'b1;
    m_last = 1;
    m_ops  = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("postrst_rsp_valid", rsp_valid, 0);
      check("postrst_busy", busy, 0);
    end

    // First tie after reset goes to requester 0.
    transact(1'b1, 32'h0000_0003, 32'd1, 1'b1, 32'h0000_0007, 32'd2, 0);
    check("postrst_tie_id", rsp_id, 0);

    // Randomized traffic.
    for (int k = 0; k < 40; k++) begin
      v = 2'($urandom_range(1, 3));
      transact(v[0], $urandom, $urandom, v[1], $urandom, $urandom,
               int'($urandom_range(0, 3)));
    end

    // Run the completion counter around to zero.
    while (m_ops != 0)
      transact(1'b1, $urandom, $urandom, 1'b1, $urandom, $urandom, 0);
    check("wrap_ops_done", ops_done, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
